// File: rtl/sm_run_ctrl.sv
// rtl/sm_run_ctrl.sv - run/step/halt/breakpoint sequencer and register dump engine for the schoolMIPS core
module sm_run_ctrl #(
    parameter int CNT_W = 16,
    parameter int PC_W  = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_arg,
    input  logic             bp_en,
    input  logic [PC_W-1:0]  bp_addr,
    input  logic [PC_W-1:0]  pc,
    output logic             cpu_en,
    output logic [4:0]       reg_addr,
    input  logic [31:0]      reg_data,
    output logic             dump_valid,
    input  logic             dump_ready,
    output logic [4:0]       dump_idx,
    output logic [31:0]      dump_data,
    output logic             halted,
    output logic             bp_hit,
    output logic [31:0]      cycle_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_STEP,
        S_DUMP_ADDR,
        S_DUMP_OUT
    } state_t;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_step_cnt;
    logic               r_skip;
    logic               r_bp_hit;
    logic [31:0]        r_cycle_cnt;
    logic [4:0]         r_reg_addr;
    logic [4:0]         r_dump_idx;
    logic [31:0]        r_dump_data;
    logic               r_dump_valid;

    logic               w_cmd_acc;
    logic               w_at_bp;
    logic               w_bp_stop;
    logic               w_run_like;
    logic               w_cpu_en;
    logic               w_start;
    logic               w_step_nz;

    assign w_cmd_acc  = cmd_valid && cmd_ready;
    assign w_at_bp    = bp_en && (pc == bp_addr);
    // The skip flag lets a resume from a breakpoint execute the instruction it stopped on.
    assign w_bp_stop  = w_at_bp && !r_skip;
    assign w_run_like = (r_state == S_RUN) || (r_state == S_STEP);
    // Gated by rst_n as well so the CPU freezes the instant reset is raised.
    assign w_cpu_en   = w_run_like && !w_bp_stop && !rst_n;
    assign w_step_nz  = (cmd_arg != '0);
    assign w_start    = (r_state == S_IDLE) && w_cmd_acc &&
                        ((cmd_op == OP_RUN) || ((cmd_op == OP_STEP) && w_step_nz));

    assign cpu_en     = w_cpu_en;
    assign cmd_ready  = (r_state == S_IDLE) || (r_state == S_RUN);
    assign halted     = (r_state == S_IDLE);
    assign bp_hit     = r_bp_hit;
    assign cycle_cnt  = r_cycle_cnt;
    assign reg_addr   = r_reg_addr;
    assign dump_idx   = r_dump_idx;
    assign dump_data  = r_dump_data;
    assign dump_valid = r_dump_valid;

    // State register.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    case (cmd_op)
                        OP_RUN:  w_next = S_RUN;
                        OP_STEP: if (w_step_nz) w_next = S_STEP;
                        OP_DUMP: w_next = S_DUMP_ADDR;
                        default: w_next = S_IDLE;
                    endcase
                end
            end
            S_RUN: begin
                if (w_bp_stop || (w_cmd_acc && (cmd_op == OP_HALT))) w_next = S_IDLE;
            end
            S_STEP: begin
                if (w_bp_stop || (r_step_cnt == CNT_W'(1))) w_next = S_IDLE;
            end
            S_DUMP_ADDR: w_next = S_DUMP_OUT;
            S_DUMP_OUT: begin
                if (dump_ready) w_next = (r_dump_idx == 5'd31) ? S_IDLE : S_DUMP_ADDR;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Step counter, breakpoint skip flag and sticky breakpoint-hit flag.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_step_cnt <= '0;
            r_skip     <= 1'b0;
            r_bp_hit   <= 1'b0;
        end else begin
            if ((r_state == S_IDLE) && w_cmd_acc && (cmd_op == OP_STEP))
                r_step_cnt <= cmd_arg;
            else if ((r_state == S_STEP) && w_cpu_en)
                r_step_cnt <= r_step_cnt - CNT_W'(1);

            if (w_start)       r_skip <= w_at_bp;
            else if (w_cpu_en) r_skip <= 1'b0;

            if (w_run_like && w_bp_stop) r_bp_hit <= 1'b1;
            else if (w_cmd_acc)          r_bp_hit <= 1'b0;
        end
    end

    // Count every clock in which the CPU was allowed to advance.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n)         r_cycle_cnt <= '0;
        else if (w_cpu_en) r_cycle_cnt <= r_cycle_cnt + 32'd1;
    end

    // Register dump: address, settle a cycle, capture, then hold until consumed.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_reg_addr   <= '0;
            r_dump_idx   <= '0;
            r_dump_data  <= '0;
            r_dump_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_acc && (cmd_op == OP_DUMP)) begin
                        r_reg_addr <= '0;
                        r_dump_idx <= '0;
                    end
                end
                S_DUMP_ADDR: begin
                    r_dump_data  <= reg_data;
                    r_dump_valid <= 1'b1;
                end
                S_DUMP_OUT: begin
                    if (dump_ready) begin
                        r_dump_valid <= 1'b0;
                        if (r_dump_idx == 5'd31) begin
                            r_dump_idx <= '0;
                            r_reg_addr <= '0;
                        end else begin
                            r_dump_idx <= r_dump_idx + 5'd1;
                            r_reg_addr <= r_reg_addr + 5'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sm_run_ctrl.sv
// tb/tb_sm_run_ctrl.sv - directed-vector bench for sm_run_ctrl with a straight-line CPU and register file model
module tb_sm_run_ctrl;

    localparam int CNT_W = 16;
    localparam int PC_W  = 32;

    localparam logic [1:0] OP_RUN  = 2'b00;
    localparam logic [1:0] OP_STEP = 2'b01;
    localparam logic [1:0] OP_HALT = 2'b10;
    localparam logic [1:0] OP_DUMP = 2'b11;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [CNT_W-1:0] cmd_arg;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             cpu_en;
    logic [4:0]       reg_addr;
    logic [31:0]      reg_data;
    logic             dump_valid;
    logic             dump_ready;
    logic [4:0]       dump_idx;
    logic [31:0]      dump_data;
    logic             halted;
    logic             bp_hit;
    logic [31:0]      cycle_cnt;

    logic [31:0]      rf [32];
    logic [31:0]      cap [32];

    int n_vec;
    int n_bad;

    sm_run_ctrl #(.CNT_W(CNT_W), .PC_W(PC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_arg    (cmd_arg),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .cpu_en     (cpu_en),
        .reg_addr   (reg_addr),
        .reg_data   (reg_data),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_idx   (dump_idx),
        .dump_data  (dump_data),
        .halted     (halted),
        .bp_hit     (bp_hit),
        .cycle_cnt  (cycle_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Straight-line program: PC advances one word per enabled cycle.
    always @(posedge clk or posedge rst_n) begin
        if (rst_n)       pc <= '0;
        else if (cpu_en) pc <= pc + 32'd4;
    end

    assign reg_data = rf[reg_addr];

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        cmd_valid  = 1'b0;
        cmd_op     = OP_HALT;
        cmd_arg    = '0;
        dump_ready = 1'b1;
        rst_n      = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
    endtask

    // Present a command and return 1 ns after the edge that accepted it.
    task automatic send(input logic [1:0] op, input logic [CNT_W-1:0] arg);
        logic rdy;
        bit   done;
        done      = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        for (int i = 0; i < 50 && !done; i++) begin
            rdy = cmd_ready;
            @(posedge clk);
            #1;
            if (rdy) done = 1;
        end
        cmd_valid = 1'b0;
        if (!done) chk_eq("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_halted();
        bit done;
        done = 0;
        for (int i = 0; i < 400 && !done; i++) begin
            if (halted) done = 1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) chk_eq("halt_timeout", 32'd0, 32'd1);
    endtask

    // Run one DUMP, optionally stalling dump_ready for hold_n cycles on word hold_idx.
    task automatic run_dump(input int hold_idx, input int hold_n,
                            output int cycles, output int words, output int seq_err,
                            output int data_err, output int stable_err, output int rdy_err,
                            output int held);
        logic [31:0] snap_data;
        logic [4:0]  snap_idx;
        bit          done;
        cycles = 0; words = 0; seq_err = 0; data_err = 0; stable_err = 0; rdy_err = 0; held = 0;
        snap_data = '0; snap_idx = '0; done = 0;
        send(OP_DUMP, '0);
        for (int i = 0; i < 300 && !done; i++) begin
            if (cpu_en || cmd_ready) rdy_err++;
            if (dump_valid && (int'(dump_idx) == hold_idx) && (held < hold_n)) begin
                dump_ready = 1'b0;
                if (held == 0) begin
                    snap_data = dump_data;
                    snap_idx  = dump_idx;
                end else if (dump_data !== snap_data || dump_idx !== snap_idx || !dump_valid) begin
                    stable_err++;
                end
                held++;
            end else begin
                dump_ready = 1'b1;
            end
            if (dump_valid && dump_ready) begin
                if (words < 32) begin
                    if (int'(dump_idx) != words) seq_err++;
                    if (dump_data !== rf[words]) data_err++;
                    cap[words] = dump_data;
                end
                words++;
            end
            @(posedge clk);
            #1;
            cycles++;
            if (halted) done = 1;
        end
        dump_ready = 1'b1;
    endtask

    initial begin
        int cyc, wrd, se, de, ste, re, hd;
        n_vec = 0;
        n_bad = 0;
        bp_en = 1'b0;
        bp_addr = '0;
        for (int i = 0; i < 32; i++) rf[i] = 32'hA500_0000 | i;
        rf[0] = 32'h0000_0000;
        rf[8] = 32'h0000_1234;
        rf[9] = 32'hFFFF_FFFF;
        for (int i = 0; i < 32; i++) cap[i] = 32'hDEAD_BEEF;

        // Reset state
        do_reset();
        chk_eq("rst_cpu_en",     {31'd0, cpu_en},     32'd0);
        chk_eq("rst_halted",     {31'd0, halted},     32'd1);
        chk_eq("rst_cmd_ready",  {31'd0, cmd_ready},  32'd1);
        chk_eq("rst_bp_hit",     {31'd0, bp_hit},     32'd0);
        chk_eq("rst_cycle_cnt",  cycle_cnt,           32'd0);
        chk_eq("rst_dump_valid", {31'd0, dump_valid}, 32'd0);
        chk_eq("rst_reg_addr",   {27'd0, reg_addr},   32'd0);
        chk_eq("rst_dump_data",  dump_data,           32'd0);

        // STEP 0 produces nothing, STEP 5 produces exactly five cycles
        send(OP_STEP, 16'd0);
        chk_eq("step0_halted", {31'd0, halted}, 32'd1);
        chk_eq("step0_cnt",    cycle_cnt,       32'd0);
        send(OP_STEP, 16'd5);
        chk_eq("step5_running", {31'd0, halted},    32'd0);
        chk_eq("step5_ready",   {31'd0, cmd_ready}, 32'd0);
        wait_halted();
        chk_eq("step5_cnt", cycle_cnt,    32'd5);
        chk_eq("step5_pc",  pc,           32'd20);
        chk_eq("step5_en",  {31'd0, cpu_en}, 32'd0);

        // RUN into a breakpoint at 0x10, then step past it
        do_reset();
        bp_en = 1'b1;
        bp_addr = 32'h10;
        send(OP_RUN, '0);
        wait_halted();
        chk_eq("bp_hit",     {31'd0, bp_hit}, 32'd1);
        chk_eq("bp_pc",      pc,              32'h10);
        chk_eq("bp_cnt",     cycle_cnt,       32'd4);
        chk_eq("bp_cpu_en",  {31'd0, cpu_en}, 32'd0);
        send(OP_STEP, 16'd1);
        chk_eq("bp_clear",   {31'd0, bp_hit}, 32'd0);
        wait_halted();
        chk_eq("bp_step_pc",  pc,        32'h14);
        chk_eq("bp_step_cnt", cycle_cnt, 32'd5);
        bp_en = 1'b0;

        // RUN, a discarded STEP, then HALT accepted in the 37th enabled cycle
        do_reset();
        send(OP_RUN, '0);
        send(OP_STEP, 16'd3);
        chk_eq("run_step_ignored", {31'd0, halted},    32'd0);
        chk_eq("run_ready",        {31'd0, cmd_ready}, 32'd1);
        repeat (35) @(posedge clk);
        #1;
        send(OP_HALT, '0);
        chk_eq("halt_cpu_en", {31'd0, cpu_en}, 32'd0);
        chk_eq("halt_halted", {31'd0, halted}, 32'd1);
        chk_eq("halt_cnt",    cycle_cnt,       32'd37);
        chk_eq("halt_pc",     pc,              32'd148);

        // Full dump with dump_ready high
        do_reset();
        run_dump(-1, 0, cyc, wrd, se, de, ste, re, hd);
        chk_eq("dump_cycles", cyc, 32'd64);
        chk_eq("dump_words",  wrd, 32'd32);
        chk_eq("dump_seq",    se,  32'd0);
        chk_eq("dump_data",   de,  32'd0);
        chk_eq("dump_busy",   re,  32'd0);
        chk_eq("dump_w0",     cap[0], 32'h0000_0000);
        chk_eq("dump_w8",     cap[8], 32'h0000_1234);
        chk_eq("dump_w9",     cap[9], 32'hFFFF_FFFF);
        chk_eq("dump_end_idx", {27'd0, dump_idx}, 32'd0);

        // Dump with a 10-cycle stall on word 3
        do_reset();
        run_dump(3, 10, cyc, wrd, se, de, ste, re, hd);
        chk_eq("bpres_held",   hd,  32'd10);
        chk_eq("bpres_stable", ste, 32'd0);
        chk_eq("bpres_seq",    se,  32'd0);
        chk_eq("bpres_words",  wrd, 32'd32);
        chk_eq("bpres_data",   de,  32'd0);
        chk_eq("bpres_cycles", cyc, 32'd74);

        // Reset in the middle of a long STEP
        do_reset();
        send(OP_STEP, 16'd100);
        repeat (10) @(posedge clk);
        #1;
        chk_eq("midstep_cnt", cycle_cnt, 32'd10);
        #2;
        rst_n = 1'b1;
        #1;
        chk_eq("midstep_cpu_en", {31'd0, cpu_en},    32'd0);
        chk_eq("midstep_halted", {31'd0, halted},    32'd1);
        chk_eq("midstep_cyc0",   cycle_cnt,          32'd0);
        chk_eq("midstep_ready",  {31'd0, cmd_ready}, 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        send(OP_STEP, 16'd2);
        wait_halted();
        chk_eq("after_step2_cnt", cycle_cnt, 32'd2);
        chk_eq("after_step2_pc",  pc,        32'd8);

        // Reset in the middle of a DUMP
        send(OP_DUMP, '0);
        repeat (7) @(posedge clk);
        #1;
        chk_eq("middump_busy", {31'd0, halted}, 32'd0);
        #2;
        rst_n = 1'b1;
        #1;
        chk_eq("middump_valid",  {31'd0, dump_valid}, 32'd0);
        chk_eq("middump_idx",    {27'd0, dump_idx},   32'd0);
        chk_eq("middump_data",   dump_data,           32'd0);
        chk_eq("middump_addr",   {27'd0, reg_addr},   32'd0);
        chk_eq("middump_halted", {31'd0, halted},     32'd1);
        chk_eq("middump_cyc0",   cycle_cnt,           32'd0);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        send(OP_STEP, 16'd2);
        wait_halted();
        chk_eq("post_dump_step2", cycle_cnt, 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
